// File: rtl/axi4_lite_write_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite write slave among N_MASTERS masters.
// It carries one complete write at a time: it accepts AW+W from the granted master,
// issues them downstream, collects B, and returns B to the same master.
// Optional feature: define AXI4_LITE_WRITE_ARB_ERRCNT_EN to add err_count_o, a saturating
// 16-bit count of completed writes whose response was not OKAY.
module axi4_lite_write_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int DEPTH     = 4,
    parameter int DATA_SIZE = 32,
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int SW       = DATA_SIZE / 8
) (
    input  logic                        clk_i,
    input  logic                        rst_clk_ni,
    input  logic [N_MASTERS*AW-1:0]     s_awaddr_i,
    input  logic [N_MASTERS-1:0]        s_awvalid_i,
    output logic [N_MASTERS-1:0]        s_awready_o,
    input  logic [N_MASTERS*DATA_SIZE-1:0] s_wdata_i,
    input  logic [N_MASTERS*SW-1:0]     s_wstrb_i,
    input  logic [N_MASTERS-1:0]        s_wvalid_i,
    output logic [N_MASTERS-1:0]        s_wready_o,
    output logic [N_MASTERS*2-1:0]      s_bresp_o,
    output logic [N_MASTERS-1:0]        s_bvalid_o,
    input  logic [N_MASTERS-1:0]        s_bready_i,
    output logic [AW-1:0]               m_awaddr_o,
    output logic                        m_awvalid_o,
    input  logic                        m_awready_i,
    output logic [DATA_SIZE-1:0]        m_wdata_o,
    output logic [SW-1:0]               m_wstrb_o,
    output logic                        m_wvalid_o,
    input  logic                        m_wready_i,
    input  logic [1:0]                  m_bresp_i,
    input  logic                        m_bvalid_i,
    output logic                        m_bready_o,
    output logic [N_MASTERS-1:0]        grant_o,
    output logic                        busy_o
`ifdef AXI4_LITE_WRITE_ARB_ERRCNT_EN
    ,
    output logic [15:0]                 err_count_o
`endif
);

    localparam int IDXW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    // One-hot state encoding
    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_ACCEPT = 5'b00010,
        ST_ISSUE  = 5'b00100,
        ST_RESP   = 5'b01000,
        ST_RETURN = 5'b10000
    } state_e;

    state_e                     state_q;
    logic [IDXW-1:0]            rr_q;
    logic [IDXW-1:0]            gidx_q;
    logic [N_MASTERS-1:0]       grant_q;
    logic                       busy_q;
    logic [N_MASTERS-1:0]       s_awready_q;
    logic [N_MASTERS-1:0]       s_wready_q;
    logic [N_MASTERS-1:0]       s_bvalid_q;
    logic [N_MASTERS*2-1:0]     s_bresp_q;
    logic [AW-1:0]              m_awaddr_q;
    logic [DATA_SIZE-1:0]       m_wdata_q;
    logic [SW-1:0]              m_wstrb_q;
    logic                       m_awvalid_q;
    logic                       m_wvalid_q;
    logic                       m_bready_q;

    logic [N_MASTERS-1:0]       req;
    logic                       pick_valid_d;
    logic [IDXW-1:0]            pick_idx_d;
    logic [N_MASTERS-1:0]       pick_oh_d;
    logic                       aw_done;
    logic                       w_done;

    // A master only requests when it offers both address and data
    assign req = s_awvalid_i & s_wvalid_i;

    // Each downstream channel is finished once its valid is gone or handshakes this cycle
    assign aw_done = !m_awvalid_q || m_awready_i;
    assign w_done  = !m_wvalid_q  || m_wready_i;

    // Round-robin pick: first requester strictly after the last completed owner
    always_comb begin
        int idx;
        idx          = 0;
        pick_valid_d = 1'b0;
        pick_idx_d   = '0;
        pick_oh_d    = '0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            idx = (int'(rr_q) + k) % N_MASTERS;
            if (!pick_valid_d && req[IDXW'(idx)]) begin
                pick_valid_d = 1'b1;
                pick_idx_d   = IDXW'(idx);
            end
        end
        if (pick_valid_d) begin
            pick_oh_d[pick_idx_d] = 1'b1;
        end
    end

    // Transaction FSM with all handshake and datapath outputs registered
    always_ff @(posedge clk_i or negedge rst_clk_ni) begin
        if (!rst_clk_ni) begin
            state_q     <= ST_IDLE;
            rr_q        <= IDXW'(N_MASTERS - 1);
            gidx_q      <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            s_awready_q <= '0;
            s_wready_q  <= '0;
            s_bvalid_q  <= '0;
            s_bresp_q   <= '0;
            m_awaddr_q  <= '0;
            m_wdata_q   <= '0;
            m_wstrb_q   <= '0;
            m_awvalid_q <= 1'b0;
            m_wvalid_q  <= 1'b0;
            m_bready_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid_d) begin
                        gidx_q      <= pick_idx_d;
                        grant_q     <= pick_oh_d;
                        s_awready_q <= pick_oh_d;
                        s_wready_q  <= pick_oh_d;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    s_awready_q <= '0;
                    s_wready_q  <= '0;
                    m_awaddr_q  <= s_awaddr_i[gidx_q*AW +: AW];
                    m_wdata_q   <= s_wdata_i[gidx_q*DATA_SIZE +: DATA_SIZE];
                    m_wstrb_q   <= s_wstrb_i[gidx_q*SW +: SW];
                    m_awvalid_q <= 1'b1;
                    m_wvalid_q  <= 1'b1;
                    state_q     <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (m_awvalid_q && m_awready_i) begin
                        m_awvalid_q <= 1'b0;
                    end
                    if (m_wvalid_q && m_wready_i) begin
                        m_wvalid_q <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        m_bready_q <= 1'b1;
                        state_q    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (m_bvalid_i) begin
                        m_bready_q               <= 1'b0;
                        s_bresp_q[gidx_q*2 +: 2] <= m_bresp_i;
                        s_bvalid_q[gidx_q]       <= 1'b1;
                        state_q                  <= ST_RETURN;
                    end
                end
                ST_RETURN: begin
                    if (s_bready_i[gidx_q]) begin
                        s_bvalid_q <= '0;
                        rr_q       <= gidx_q;
                        grant_q    <= '0;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    s_awready_q <= '0;
                    s_wready_q  <= '0;
                    s_bvalid_q  <= '0;
                    m_awvalid_q <= 1'b0;
                    m_wvalid_q  <= 1'b0;
                    m_bready_q  <= 1'b0;
                    grant_q     <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef AXI4_LITE_WRITE_ARB_ERRCNT_EN
    logic [15:0] err_count_q;

    // Count completed writes whose returned response was not OKAY, saturating at all-ones
    always_ff @(posedge clk_i or negedge rst_clk_ni) begin
        if (!rst_clk_ni) begin
            err_count_q <= '0;
        end else if (state_q == ST_RETURN && s_bready_i[gidx_q] &&
                     s_bresp_q[gidx_q*2 +: 2] != 2'b00 && err_count_q != 16'hFFFF) begin
            err_count_q <= err_count_q + 16'd1;
        end
    end

    assign err_count_o = err_count_q;
`endif

    assign s_awready_o = s_awready_q;
    assign s_wready_o  = s_wready_q;
    assign s_bvalid_o  = s_bvalid_q;
    assign s_bresp_o   = s_bresp_q;
    assign m_awaddr_o  = m_awaddr_q;
    assign m_wdata_o   = m_wdata_q;
    assign m_wstrb_o   = m_wstrb_q;
    assign m_awvalid_o = m_awvalid_q;
    assign m_wvalid_o  = m_wvalid_q;
    assign m_bready_o  = m_bready_q;
    assign grant_o     = grant_q;
    assign busy_o      = busy_q;

endmodule
